// File: rtl/xvc_jtag_shifter.sv
// xvc_jtag_shifter: drives TCK/TMS/TDI for an XVC shift command and returns captured TDO bytes
module xvc_jtag_shifter #(
    parameter int TCK_DIV  = 4,
    parameter int MAX_BITS = 32768
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_tms,
    input  logic [7:0]  in_tdi,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_tdo,
    output logic        done_port,
    output logic        error,
    output logic        jtag_tck,
    output logic        jtag_tms,
    output logic        jtag_tdi,
    input  logic        jtag_tdo
);
    typedef enum logic [2:0] {IDLE, FETCH, TCK_LOW, TCK_HIGH, EMIT, FINISH} state_t;

    localparam logic [31:0] MAX_LEN  = 32'(MAX_BITS);
    localparam logic [7:0]  DIV_LAST = 8'(TCK_DIV - 1);

    state_t      state, state_next;
    logic [31:0] remaining;
    logic [7:0]  tms_r, tdi_r, tdo_r, cnt;
    logic [2:0]  idx;
    logic        err_r, half_end, byte_end;

    // next state: a half-period ends when the divider reaches its last count
    always_comb begin
        state_next = state;
        half_end = cnt == DIV_LAST;
        byte_end = remaining == 32'd1 || idx == 3'd7;
        case (state)
            IDLE:     if (cmd_valid && cmd_ready)
                          state_next = (cmd_len == 32'd0 || cmd_len > MAX_LEN) ? FINISH : FETCH;
            FETCH:    if (in_valid && in_ready) state_next = TCK_LOW;
            TCK_LOW:  if (half_end) state_next = TCK_HIGH;
            TCK_HIGH: if (half_end) state_next = byte_end ? EMIT : TCK_LOW;
            EMIT:     if (out_ready) state_next = (remaining != 32'd0) ? FETCH : FINISH;
            FINISH:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // registered handshakes, JTAG pins and shift datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_ready <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_tdo   <= 8'd0;
            done_port <= 1'b0;
            error     <= 1'b0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            remaining <= 32'd0;
            tms_r     <= 8'd0;
            tdi_r     <= 8'd0;
            tdo_r     <= 8'd0;
            cnt       <= 8'd0;
            idx       <= 3'd0;
            err_r     <= 1'b0;
        end else begin
            cmd_ready <= state_next == IDLE;
            in_ready  <= state_next == FETCH;
            out_valid <= state_next == EMIT;
            done_port <= state == FINISH;
            error     <= state == FINISH && err_r;
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    remaining <= cmd_len;
                    err_r     <= cmd_len > MAX_LEN;
                end
                FETCH: if (in_valid && in_ready) begin
                    tms_r    <= in_tms;
                    tdi_r    <= in_tdi;
                    tdo_r    <= 8'd0;
                    idx      <= 3'd0;
                    cnt      <= 8'd0;
                    jtag_tms <= in_tms[0];
                    jtag_tdi <= in_tdi[0];
                end
                TCK_LOW: if (half_end) begin
                    tdo_r[idx] <= jtag_tdo;
                    jtag_tck   <= 1'b1;
                    cnt        <= 8'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                TCK_HIGH: if (half_end) begin
                    jtag_tck  <= 1'b0;
                    cnt       <= 8'd0;
                    remaining <= remaining - 32'd1;
                    if (byte_end) begin
                        out_tdo <= tdo_r;
                    end else begin
                        idx      <= idx + 3'd1;
                        jtag_tms <= tms_r[idx + 3'd1];
                        jtag_tdi <= tdi_r[idx + 3'd1];
                    end
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xvc_jtag_shifter.sv
// tb_xvc_jtag_shifter: directed checks of the XVC JTAG shifter
module tb_xvc_jtag_shifter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid, cmd_ready, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] cmd_len;
    logic [7:0]  in_tms, in_tdi, out_tdo;
    logic        done_port, error, jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
    logic        tdo_loop, tdo_const;

    int total = 0;
    int bad = 0;
    int rises, tms_ones, pairs, emits, done_cnt, high_cnt, rdy_seen, stall_hi, stall_drop;
    logic last_err;
    logic [7:0] tms_v[3], tdi_v[3], got[3];

    xvc_jtag_shifter dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_tms(in_tms), .in_tdi(in_tdi),
        .out_valid(out_valid), .out_ready(out_ready), .out_tdo(out_tdo),
        .done_port(done_port), .error(error),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
    );

    always #5 clock = ~clock;

    assign jtag_tdo = tdo_loop ? jtag_tdi : tdo_const;

    // TCK edge counters seen from the target side
    always @(posedge jtag_tck) begin
        rises++;
        if (jtag_tms) tms_ones++;
    end

    // handshake and pin activity sampled at the active edge
    always @(posedge clock) begin
        if (in_valid && in_ready) pairs++;
        if (out_valid && out_ready) emits++;
        if (in_ready) rdy_seen++;
        if (jtag_tck) high_cnt++;
        if (done_port) begin
            done_cnt++;
            last_err = error;
        end
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic clear_mon();
        rises = 0; tms_ones = 0; pairs = 0; emits = 0; done_cnt = 0;
        high_cnt = 0; rdy_seen = 0; stall_hi = 0; stall_drop = 0; last_err = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] len);
        int t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clock); t++; end
        check("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len = len;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input logic [7:0] tms, input logic [7:0] tdi);
        int t = 0;
        while (!in_ready && t < 1000) begin @(negedge clock); t++; end
        check("in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_tms = tms;
        in_tdi = tdi;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int i, input int stall);
        int t = 0;
        while (!out_valid && t < 1000) begin @(negedge clock); t++; end
        check("out_valid", out_valid, 1);
        got[i] = out_tdo;
        repeat (stall) begin
            @(negedge clock);
            if (jtag_tck) stall_hi++;
            if (!out_valid) stall_drop++;
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err);
        int t = 0;
        while (done_cnt == 0 && t < 200) begin @(negedge clock); t++; end
        check("done_count", done_cnt, 1);
        check("done_error", last_err, exp_err);
    endtask

    task automatic run_cmd(input logic [31:0] len, input int n, input int stall);
        clear_mon();
        send_cmd(len);
        fork
            for (int i = 0; i < n; i++) feed(tms_v[i], tdi_v[i]);
            for (int j = 0; j < n; j++) collect(j, j == 0 ? stall : 0);
        join
        wait_done(1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        cmd_valid = 0; cmd_len = 0; in_valid = 0; in_tms = 0; in_tdi = 0; out_ready = 0;
        tdo_loop = 1; tdo_const = 0;
        clear_mon();
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_tdo", out_tdo, 0);
        check("rst_done", done_port, 0);
        check("rst_error", error, 0);
        check("rst_tck", jtag_tck, 0);
        check("rst_tms", jtag_tms, 1);
        check("rst_tdi", jtag_tdi, 0);
        reset = 0;
        @(negedge clock);
        check("idle_ready", cmd_ready, 1);

        clear_mon();
        cmd_valid = 1; cmd_len = 0;
        @(negedge clock);
        cmd_valid = 0;
        check("zero_done_early", done_port, 0);
        @(negedge clock);
        check("zero_done", done_port, 1);
        check("zero_error", error, 0);
        @(negedge clock);
        check("zero_rises", rises, 0);
        check("zero_in_ready", rdy_seen, 0);

        tdo_loop = 1;
        tms_v[0] = 8'h00; tdi_v[0] = 8'hA5;
        run_cmd(8, 1, 0);
        check("byte_tdo", got[0], 8'hA5);
        check("byte_rises", rises, 8);
        check("byte_high_clocks", high_cnt, 32);
        check("byte_tms_ones", tms_ones, 0);
        check("byte_pairs", pairs, 1);
        check("byte_emits", emits, 1);

        tdo_loop = 0; tdo_const = 1;
        tms_v[0] = 8'h1F; tdi_v[0] = 8'hFF;
        run_cmd(5, 1, 0);
        check("part_tdo", got[0], 8'h1F);
        check("part_rises", rises, 5);
        check("part_tms_ones", tms_ones, 5);
        check("part_pairs", pairs, 1);

        tdo_loop = 1;
        tms_v[0] = 8'h00; tms_v[1] = 8'h00; tms_v[2] = 8'h00;
        tdi_v[0] = 8'h3C; tdi_v[1] = 8'h96; tdi_v[2] = 8'hFA;
        run_cmd(20, 3, 50);
        check("multi_tdo0", got[0], 8'h3C);
        check("multi_tdo1", got[1], 8'h96);
        check("multi_tdo2", got[2], 8'h0A);
        check("multi_rises", rises, 20);
        check("multi_stall_tck", stall_hi, 0);
        check("multi_stall_valid", stall_drop, 0);
        check("multi_pairs", pairs, 3);
        check("multi_emits", emits, 3);

        reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);
        clear_mon();
        send_cmd(32769);
        wait_done(1'b1);
        check("over_in_ready", rdy_seen, 0);
        check("over_rises", rises, 0);
        check("over_tck", jtag_tck, 0);
        check("over_tms", jtag_tms, 1);
        check("over_tdi", jtag_tdi, 0);

        clear_mon();
        tdo_loop = 1;
        send_cmd(16);
        feed(8'h00, 8'hFF);
        t = 0;
        while (rises < 3 && t < 500) begin @(negedge clock); t++; end
        check("abort_rise3", rises, 3);
        check("abort_tck_high", jtag_tck, 1);
        check("abort_tms_low", jtag_tms, 0);
        reset = 1;
        @(negedge clock);
        check("abort_tck", jtag_tck, 0);
        check("abort_tms", jtag_tms, 1);
        check("abort_out_valid", out_valid, 0);
        reset = 0;
        repeat (20) @(negedge clock);
        check("abort_no_done", done_cnt, 0);
        check("abort_rises", rises, 3);

        tms_v[0] = 8'h00; tdi_v[0] = 8'h5A;
        run_cmd(8, 1, 0);
        check("after_tdo", got[0], 8'h5A);
        check("after_rises", rises, 8);
        check("after_pairs", pairs, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
